sop_share_absdiff_pipe: RTL and testbench



---
 rtl/sop_share_pkg.sv | 32 +++
 rtl/sop_share_plane.sv | 25 ++
 rtl/sop_share_absdiff_pipe.sv | 154 +++++++++++++++
 tb/tb_sop_share_absdiff_pipe.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sop_share_pkg.sv
// Shared types and helpers for the programmable shared-product |a-b| evaluator.
// The monitor in the top is enabled by defining SOP_ABSDIFF_ERR_MON_EN.
package sop_share_pkg;

  localparam int MAX_NIN = 16;
  localparam int ABS_W   = 32;

  typedef struct packed {
    logic [MAX_NIN-1:0] pol;
    logic [MAX_NIN-1:0] use_m;
  } cfg_row_t;

  typedef enum logic [1:0] {ROW_PROD, ROW_SEL, ROW_DROP} row_kind_t;

  function automatic row_kind_t row_kind(input int unsigned addr, input int unsigned pit,
                                         input int unsigned out_w);
    if (addr < pit)              return ROW_PROD;
    else if (addr < pit + out_w) return ROW_SEL;
    else                         return ROW_DROP;
  endfunction

  // One extra bit so |approx - exact| never wraps when approx is wider than exact.
  function automatic int unsigned err_width(input int unsigned in_w, input int unsigned out_w);
    return ((out_w > in_w) ? out_w : in_w) + 1;
  endfunction

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sop_share_plane.sv
// Combinational AND-plane (products from x) and OR-plane (output bits from registered products).
module sop_share_plane #(
  parameter int NIN   = 4,
  parameter int PIT   = 6,
  parameter int OUT_W = 2
) (
  input  logic [NIN-1:0]   x,
  input  logic [NIN-1:0]   use_m [PIT],
  input  logic [NIN-1:0]   pol   [PIT],
  input  logic [PIT-1:0]   sel   [OUT_W],
  input  logic [PIT-1:0]   prod_in,
  output logic [PIT-1:0]   prod,
  output logic [OUT_W-1:0] approx
);

  // Unused literals are forced true, so an empty use mask yields a constant 1.
  for (genvar gi = 0; gi < PIT; gi++) begin : g_and
    assign prod[gi] = &(~use_m[gi] | ~(x ^ pol[gi]));
  end

  for (genvar gi = 0; gi < OUT_W; gi++) begin : g_or
    assign approx[gi] = |(sel[gi] & prod_in);
  end

endmodule

// File: rtl/sop_share_absdiff_pipe.sv
// Two-stage programmable SOP |a-b| approximator with exact reference and error flag.
// Define SOP_ABSDIFF_ERR_MON_EN to build the err_cnt/max_err monitor.
module sop_share_absdiff_pipe
  import sop_share_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int OUT_W = IN_W,
  parameter int PIT   = 6,
  parameter int ET    = 3,
  parameter int CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_W-1:0]               in_a,
  input  logic [IN_W-1:0]               in_b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_approx,
  output logic [IN_W-1:0]               out_exact,
  output logic                          out_err_flag,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [$clog2(PIT+OUT_W)-1:0]  cfg_addr,
  input  logic [4*IN_W-1:0]             cfg_data,
  output logic [CNT_W-1:0]              err_cnt,
  output logic [IN_W-1:0]               max_err,
  input  logic                          cnt_clr
);

  localparam int NIN = 2 * IN_W;
  localparam int AW  = $clog2(PIT + OUT_W);
  localparam int EW  = err_width(IN_W, OUT_W);

  logic [NIN-1:0]   use_reg [PIT];
  logic [NIN-1:0]   pol_reg [PIT];
  logic [PIT-1:0]   sel_reg [OUT_W];

  cfg_row_t         cfg_row;
  row_kind_t        cfg_kind;
  logic             en, cfg_we, out_fire;

  logic             s1_valid_reg;
  logic [PIT-1:0]   s1_prod_reg;
  logic [IN_W-1:0]  s1_exact_reg;
  logic             s2_valid_reg;
  logic [OUT_W-1:0] s2_approx_reg;
  logic [IN_W-1:0]  s2_exact_reg;
  logic [EW-1:0]    s2_err_reg;
  logic             s2_flag_reg;

  logic [PIT-1:0]   prod;
  logic [OUT_W-1:0] approx;
  logic [EW-1:0]    err;

  // Config only lands on an empty pipe, so every in-flight entry sees one mask set.
  assign en        = ~s2_valid_reg | out_ready;
  assign cfg_ready = ~s1_valid_reg & ~s2_valid_reg;
  assign cfg_we    = cfg_valid & cfg_ready;
  assign in_ready  = en & ~cfg_we;
  assign out_fire  = s2_valid_reg & out_ready;

  assign cfg_row.use_m = MAX_NIN'(cfg_data[NIN-1:0]);
  assign cfg_row.pol   = MAX_NIN'(cfg_data[2*NIN-1:NIN]);
  assign cfg_kind      = row_kind(32'(cfg_addr), PIT, OUT_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIT; i++) begin
        use_reg[i] <= '0;
        pol_reg[i] <= '0;
      end
      for (int i = 0; i < OUT_W; i++) sel_reg[i] <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < PIT; i++) begin
        if (cfg_kind == ROW_PROD && cfg_addr == AW'(i)) begin
          use_reg[i] <= cfg_row.use_m[NIN-1:0];
          pol_reg[i] <= cfg_row.pol[NIN-1:0];
        end
      end
      for (int i = 0; i < OUT_W; i++) begin
        if (cfg_kind == ROW_SEL && cfg_addr == AW'(PIT + i)) sel_reg[i] <= cfg_data[PIT-1:0];
      end
    end
  end

  sop_share_plane #(.NIN(NIN), .PIT(PIT), .OUT_W(OUT_W)) u_plane (
    .x      ({in_b, in_a}),
    .use_m  (use_reg),
    .pol    (pol_reg),
    .sel    (sel_reg),
    .prod_in(s1_prod_reg),
    .prod   (prod),
    .approx (approx)
  );

  assign err = EW'(abs_diff(ABS_W'(approx), ABS_W'(s1_exact_reg)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_prod_reg   <= '0;
      s1_exact_reg  <= '0;
      s2_valid_reg  <= 1'b0;
      s2_approx_reg <= '0;
      s2_exact_reg  <= '0;
      s2_err_reg    <= '0;
      s2_flag_reg   <= 1'b0;
    end else if (en) begin
      s1_valid_reg  <= in_valid & in_ready;
      s1_prod_reg   <= prod;
      s1_exact_reg  <= IN_W'(abs_diff(ABS_W'(in_a), ABS_W'(in_b)));
      s2_valid_reg  <= s1_valid_reg;
      s2_approx_reg <= approx;
      s2_exact_reg  <= s1_exact_reg;
      s2_err_reg    <= err;
      s2_flag_reg   <= (int'(err) > ET);
    end
  end

  assign out_valid    = s2_valid_reg;
  assign out_approx   = s2_approx_reg;
  assign out_exact    = s2_exact_reg;
  assign out_err_flag = s2_flag_reg;

`ifdef SOP_ABSDIFF_ERR_MON_EN
  logic [CNT_W-1:0] err_cnt_reg;
  logic [IN_W-1:0]  max_err_reg;
  logic [IN_W-1:0]  err_clip;

  assign err_clip = (s2_err_reg > EW'({IN_W{1'b1}})) ? '1 : s2_err_reg[IN_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
      max_err_reg <= '0;
    end else if (cnt_clr) begin
      err_cnt_reg <= '0;
      max_err_reg <= '0;
    end else if (out_fire) begin
      if (s2_flag_reg && err_cnt_reg != '1) err_cnt_reg <= err_cnt_reg + 1'b1;
      if (err_clip > max_err_reg) max_err_reg <= err_clip;
    end
  end

  assign err_cnt = err_cnt_reg;
  assign max_err = max_err_reg;
`else
  assign err_cnt = '0;
  assign max_err = '0;
`endif

endmodule

// File: tb/tb_sop_share_absdiff_pipe.sv
// Self-checking bench: table vectors, corner sequences and randomized traffic against a reference model.
// Two instances share stimulus: default ET=3 and ET=0 (to exercise flags and the monitor).
module tb_sop_share_absdiff_pipe;

  localparam int IN_W = 2, OUT_W = 2, PIT = 6, CNT_W = 16, AW = 3;
`ifdef SOP_ABSDIFF_ERR_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic [IN_W-1:0]  in_a = '0, in_b = '0;
  logic             out_ready = 1'b1;
  logic             cfg_valid = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [7:0]       cfg_data = '0;
  logic             cnt_clr = 1'b0;

  logic             in_ready, cfg_ready, out_valid, out_err_flag;
  logic [OUT_W-1:0] out_approx;
  logic [IN_W-1:0]  out_exact, max_err;
  logic [CNT_W-1:0] err_cnt;

  logic             z_in_ready, z_cfg_ready, z_out_valid, z_flag;
  logic [OUT_W-1:0] z_out_approx;
  logic [IN_W-1:0]  z_out_exact, z_max_err;
  logic [CNT_W-1:0] z_err_cnt;

  sop_share_absdiff_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_approx(out_approx), .out_exact(out_exact),
    .out_err_flag(out_err_flag), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .err_cnt(err_cnt), .max_err(max_err), .cnt_clr(cnt_clr)
  );

  sop_share_absdiff_pipe #(.ET(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(z_out_valid), .out_ready(out_ready), .out_approx(z_out_approx), .out_exact(z_out_exact),
    .out_err_flag(z_flag), .cfg_valid(cfg_valid), .cfg_ready(z_cfg_ready), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .err_cnt(z_err_cnt), .max_err(z_max_err), .cnt_clr(cnt_clr)
  );

  typedef struct {int approx; int exact; int err;} exp_t;
  typedef struct {int a; int b; int approx; int exact; int flag0;} vec_t;

  exp_t q[$];
  vec_t tbl[5];
  int   m_use[PIT], m_pol[PIT], m_sel[OUT_W];
  int   mc3 = 0, mm3 = 0, mc0 = 0, mm0 = 0;
  int   n_pass = 0, n_chk = 0;
  int   outs = 0, last_approx, last_exact, last_flag3, last_flag0;
  bit   g_fi, g_fo, g_fc;

  task automatic chk(string nm, int act, int req);
    n_chk++;
    if (act != req) $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, req, $time);
    else n_pass++;
  endtask

  function automatic int ref_approx(int a, int b);
    int x, r, lit;
    x = (b << IN_W) | a;
    r = 0;
    for (int o = 0; o < OUT_W; o++)
      for (int p = 0; p < PIT; p++)
        if ((m_sel[o] >> p) & 1) begin
          lit = 1;
          for (int i = 0; i < 2 * IN_W; i++)
            if (((m_use[p] >> i) & 1) && (((x >> i) & 1) != ((m_pol[p] >> i) & 1))) lit = 0;
          if (lit != 0) r |= (1 << o);
        end
    return r;
  endfunction

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < PIT; i++) begin m_use[i] = 0; m_pol[i] = 0; end
    for (int i = 0; i < OUT_W; i++) m_sel[i] = 0;
    mc3 = 0; mm3 = 0; mc0 = 0; mm0 = 0;
  endtask

  task automatic cycle();
    exp_t e;
    int a_s, b_s, ca, cd;
    @(negedge clk);
    chk("err_cnt_et3", int'(err_cnt), MON ? mc3 : 0);
    chk("max_err_et3", int'(max_err), MON ? mm3 : 0);
    chk("err_cnt_et0", int'(z_err_cnt), MON ? mc0 : 0);
    chk("max_err_et0", int'(z_max_err), MON ? mm0 : 0);
    chk("et0_out_valid", int'(z_out_valid), int'(out_valid));
    g_fi = in_valid && in_ready;
    g_fo = out_valid && out_ready;
    g_fc = cfg_valid && cfg_ready;
    a_s = in_a; b_s = in_b; ca = cfg_addr; cd = cfg_data;
    if (out_valid) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = q[0];
        chk("approx", int'(out_approx), e.approx);
        chk("exact", int'(out_exact), e.exact);
        chk("flag_et3", int'(out_err_flag), int'(e.err > 3));
        chk("flag_et0", int'(z_flag), int'(e.err > 0));
        if (g_fo) begin
          last_approx = out_approx; last_exact = out_exact;
          last_flag3 = out_err_flag; last_flag0 = z_flag;
          outs++;
          void'(q.pop_front());
          if (!cnt_clr) begin
            if (e.err > 3 && mc3 < 65535) mc3++;
            if (e.err > 0 && mc0 < 65535) mc0++;
            if (e.err > mm3) mm3 = e.err;
            if (e.err > mm0) mm0 = e.err;
          end
        end
      end
    end
    if (cnt_clr) begin mc3 = 0; mm3 = 0; mc0 = 0; mm0 = 0; end
    @(posedge clk);
    if (g_fi) begin
      e.exact  = (a_s > b_s) ? a_s - b_s : b_s - a_s;
      e.approx = ref_approx(a_s, b_s);
      e.err    = (e.approx > e.exact) ? e.approx - e.exact : e.exact - e.approx;
      q.push_back(e);
    end
    if (g_fc) begin
      if (ca < PIT) begin m_use[ca] = cd & 15; m_pol[ca] = (cd >> 4) & 15; end
      else if (ca < PIT + OUT_W) m_sel[ca - PIT] = cd & 63;
    end
    #1;
  endtask

  task automatic cfg_write(int addr, int data);
    int k = 0;
    cfg_valid = 1'b1; cfg_addr = AW'(addr); cfg_data = 8'(data);
    do begin cycle(); k++; end while (!g_fc && k < 20);
    if (!g_fc) chk("cfg_timeout", 0, 1);
    cfg_valid = 1'b0;
  endtask

  task automatic send_and_check(int a, int b, int ea, int ee, int ef0);
    int k = 0;
    int o;
    in_valid = 1'b1; in_a = IN_W'(a); in_b = IN_W'(b); out_ready = 1'b1;
    do begin cycle(); k++; end while (!g_fi && k < 20);
    in_valid = 1'b0;
    if (!g_fi) chk("send_timeout", 0, 1);
    cycle();
    chk("latency_valid", int'(out_valid), 1);
    o = outs;
    cycle();
    chk("out_fired", outs, o + 1);
    chk("vec_approx", last_approx, ea);
    chk("vec_exact", last_exact, ee);
    chk("vec_flag_et3", last_flag3, 0);
    chk("vec_flag_et0", last_flag0, ef0);
  endtask

  task automatic drain();
    int k = 0;
    in_valid = 1'b0; cfg_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    while (q.size() != 0 && k < 50) begin cycle(); k++; end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    int acc, o, k, ha, he;
    tbl[0] = '{3, 0, 0, 3, 1};
    tbl[1] = '{1, 0, 1, 1, 0};
    tbl[2] = '{2, 3, 0, 1, 1};
    tbl[3] = '{3, 3, 1, 0, 1};
    tbl[4] = '{0, 2, 0, 2, 1};
    model_clear();

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_approx", int'(out_approx), 0);
    chk("rst_out_exact", int'(out_exact), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_max_err", int'(max_err), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Table vectors: entry 0 on reset masks, the rest with row0=a[0] routed to bit 0
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin cfg_write(0, 8'h11); cfg_write(6, 8'h01); end
      send_and_check(tbl[i].a, tbl[i].b, tbl[i].approx, tbl[i].exact, tbl[i].flag0);
    end

    // Backpressure: two accepted, output held bit-stable, then in-order release
    out_ready = 1'b0; in_valid = 1'b1; acc = 0;
    in_a = 2'd1; in_b = 2'd2; cycle(); acc += int'(g_fi);
    in_a = 2'd2; in_b = 2'd0; cycle(); acc += int'(g_fi);
    in_a = 2'd3; in_b = 2'd1; cycle(); acc += int'(g_fi);
    chk("stall_accepted", acc, 2);
    chk("stall_in_ready", int'(in_ready), 0);
    ha = out_approx; he = out_exact;
    repeat (3) begin
      cycle();
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_approx", int'(out_approx), ha);
      chk("hold_exact", int'(out_exact), he);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    o = outs; out_ready = 1'b1;
    cycle();
    chk("release_first", outs, o + 1);
    chk("release_accept", int'(g_fi), 1);
    in_valid = 1'b0;
    cycle();
    chk("release_second", outs, o + 2);
    drain();

    // Config blocked while the pipe holds data
    in_valid = 1'b1; in_a = 2'd0; in_b = 2'd1; cycle(); in_valid = 1'b0;
    cfg_valid = 1'b1; cfg_addr = 3'd1; cfg_data = 8'h5a;
    chk("cfg_blocked", int'(cfg_ready), 0);
    k = 0;
    do begin cycle(); k++; end while (!g_fc && k < 10);
    chk("cfg_wait_cycles", k, 3);
    cfg_valid = 1'b0;
    drain();

    // Concurrent cfg + input on an empty pipe: cfg wins
    cfg_valid = 1'b1; cfg_addr = 3'd7; cfg_data = 8'h03;
    in_valid = 1'b1; in_a = 2'd3; in_b = 2'd0;
    cycle();
    chk("cc_cfg_fire", int'(g_fc), 1);
    chk("cc_in_blocked", int'(g_fi), 0);
    cfg_valid = 1'b0;
    cycle();
    chk("cc_in_after", int'(g_fi), 1);
    drain();

    // Randomized traffic including config rewrites and clears
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_a      = IN_W'($urandom_range(0, 3));
      in_b      = IN_W'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 9) < 7);
      cfg_valid = ($urandom_range(0, 19) == 0);
      cfg_addr  = AW'($urandom_range(0, 7));
      cfg_data  = 8'($urandom_range(0, 255));
      cnt_clr   = ($urandom_range(0, 29) == 0);
      cycle();
    end
    drain();

    // Monitor: violation counted, then cleared by a concurrent cnt_clr
    rst_n = 1'b0; #1; model_clear();
    @(posedge clk); #3 rst_n = 1'b1;
    send_and_check(3, 1, 0, 2, 1);
    chk("mon_cnt_et0", int'(z_err_cnt), MON ? 1 : 0);
    chk("mon_max_et0", int'(z_max_err), MON ? 2 : 0);
    chk("mon_cnt_et3", int'(err_cnt), 0);
    chk("mon_max_et3", int'(max_err), MON ? 2 : 0);
    cnt_clr = 1'b1;
    send_and_check(0, 3, 0, 3, 1);
    cnt_clr = 1'b0;
    chk("clr_cnt_et0", int'(z_err_cnt), 0);
    chk("clr_max_et0", int'(z_max_err), 0);

    // Asynchronous reset with S2 holding a result
    cfg_write(6, 8'h3f);
    out_ready = 1'b0; in_valid = 1'b1; in_a = 2'd2; in_b = 2'd1;
    cycle(); cycle();
    in_valid = 1'b0;
    chk("pre_rst_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", int'(out_valid), 0);
    chk("async_out_approx", int'(out_approx), 0);
    chk("async_cfg_ready", int'(cfg_ready), 1);
    model_clear();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1; out_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    send_and_check(1, 0, 0, 1, 1);

    chk("final_queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=1 required=0");
    $fatal(1, "timeout");
  end

endmodule
